// File: rtl/sram_banked_dp.sv
// Dual-port memory built from N_BANKS word-interleaved single-port banks, round-robin on bank conflicts.
// Optional conflict-cycle counter output when SRAM_BANKED_PERF_EN is defined.
module sram_banked_dp #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int N_BANKS = 2
) (
  input  logic              clk,
  input  logic              arst_n,
`ifdef SRAM_BANKED_PERF_EN
  output logic [31:0]       conflict_cnt,
`endif
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_wen,
  input  logic [63:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W/8-1:0] a_be,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_wen,
  input  logic [63:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [DATA_W/8-1:0] b_be,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata
);
  localparam int BYTES   = DATA_W / 8;
  localparam int OFF     = $clog2(BYTES);
  localparam int BANK_SH = $clog2(N_BANKS);
  localparam int BANK_IW = (BANK_SH > 0) ? BANK_SH : 1;
  localparam int ROW_W   = (ADDR_W > BANK_SH) ? ADDR_W - BANK_SH : 1;
  localparam int ROWS    = (2 ** ADDR_W) / N_BANKS;
  localparam logic [ADDR_W-1:0] BANK_MASK = ADDR_W'(N_BANKS - 1);

  logic [ADDR_W-1:0]  a_word, b_word, a_bank, b_bank;
  logic [ROW_W-1:0]   a_row, b_row;
  logic               conflict, a_acc, b_acc;
  logic               rr_q, rr_d;
  logic               a_rvalid_q, b_rvalid_q;
  logic [BANK_IW-1:0] a_bsel_q, b_bsel_q;
  logic [DATA_W-1:0]  a_hold_q, b_hold_q;
  logic [DATA_W-1:0]  bank_rd [N_BANKS];
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{a_addr, b_addr};

  assign a_word = a_addr[ADDR_W-1+OFF:OFF];
  assign b_word = b_addr[ADDR_W-1+OFF:OFF];
  assign a_bank = a_word & BANK_MASK;
  assign b_bank = b_word & BANK_MASK;
  assign a_row  = ROW_W'(a_word >> BANK_SH);
  assign b_row  = ROW_W'(b_word >> BANK_SH);

  // rr_q = 0 favours port a, 1 favours port b; only consulted on a same-bank collision
  assign conflict = a_valid & b_valid & (a_bank == b_bank);
  assign a_ready  = arst_n & (~conflict | ~rr_q);
  assign b_ready  = arst_n & (~conflict | rr_q);
  assign a_acc    = a_valid & a_ready;
  assign b_acc    = b_valid & b_ready;
  assign rr_d     = conflict ? ~rr_q : rr_q;

  for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
    logic [DATA_W-1:0] mem [ROWS];
    logic [DATA_W-1:0] rd_q;
    logic              a_sel, b_sel, en, we;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] wd;
    logic [BYTES-1:0]  be;

    assign a_sel = a_acc & (a_bank == ADDR_W'(gi));
    assign b_sel = b_acc & (b_bank == ADDR_W'(gi));
    assign en    = a_sel | b_sel;
    assign we    = a_sel ? a_wen   : b_wen;
    assign row   = a_sel ? a_row   : b_row;
    assign wd    = a_sel ? a_wdata : b_wdata;
    assign be    = a_sel ? a_be    : b_be;

    // Contents are deliberately not reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
      if (en && we) begin
        for (int i = 0; i < BYTES; i++) begin
          if (be[i]) mem[row][i*8 +: 8] <= wd[i*8 +: 8];
        end
      end
      if (en && !we) rd_q <= mem[row];
    end

    assign bank_rd[gi] = rd_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_q       <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_bsel_q   <= '0;
      b_bsel_q   <= '0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      a_rvalid_q <= a_acc & ~a_wen;
      b_rvalid_q <= b_acc & ~b_wen;
      a_bsel_q   <= BANK_IW'(a_bank);
      b_bsel_q   <= BANK_IW'(b_bank);
      if (a_rvalid_q) a_hold_q <= bank_rd[a_bsel_q];
      if (b_rvalid_q) b_hold_q <= bank_rd[b_bsel_q];
    end
  end

  // Bank output registers may be reused by the other port later, so hold a private copy
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? bank_rd[a_bsel_q] : a_hold_q;
  assign b_rdata  = b_rvalid_q ? bank_rd[b_bsel_q] : b_hold_q;

`ifdef SRAM_BANKED_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) conflict_cnt_q <= '0;
    else         conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: doc/sram_banked_dp.md
SRAM_BANKED_DP -- requirements
Module: sram_banked_dp

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: word-address bits; total depth 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32: word width; a multiple of 8 in {32,64,128}.
REQ-003 SHALL have parameter N_BANKS, default 2: single-port banks, power of 2, at most 2**ADDR_W; each bank holds 2**ADDR_W/N_BANKS words.
REQ-004 SHALL have ports clk  in  1  system clock; one clock; all state on rising edge.
REQ-005 SHALL have port arst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have, for each port p in {a,b}: p_valid  in  1  request present.
REQ-007 SHALL have p_ready  out  1  request accepted this cycle when high together with p_valid.
REQ-008 SHALL have p_wen  in  1  1=write, 0=read.
REQ-009 SHALL have p_addr  in  64  byte address.
REQ-010 SHALL have p_wdata  in  DATA_W  write data.
REQ-011 SHALL have p_be  in  DATA_W/8  byte enables, writes only.
REQ-012 SHALL have p_rvalid  out  1  read data valid.
REQ-013 SHALL have p_rdata  out  DATA_W  read data.

Function
REQ-014 SHALL form word address as p_addr[ADDR_W-1+OFF:OFF] with OFF=log2(DATA_W/8); lower and upper bits ignored, so addresses wrap modulo depth.
REQ-015 SHALL interleave banks: bank = word address mod N_BANKS; bank row = word address / N_BANKS.
REQ-016 SHALL accept a request when p_valid and p_ready are both high; p_ready is combinational and never depends on p_rvalid.
REQ-017 SHALL drive p_ready high whenever port p's bank differs from the other port's bank, or the other port is not valid.
REQ-018 SHALL resolve same-bank requests from both ports by round-robin: the grant goes to the port named by pointer rr; the loser's p_ready is low; rr toggles after each such conflict grant.
REQ-019 SHALL update only bytes i with p_be[i]=1 on an accepted write, visible to reads accepted on the next cycle or later.
REQ-020 SHALL return read data exactly one cycle after acceptance: p_rvalid=1 for one cycle, p_rdata equal to the stored word.
REQ-021 SHALL hold p_rdata at its last value while p_rvalid=0.
REQ-022 SHALL not backpressure responses; a new read can be accepted each cycle per port (throughput 1/cycle/port when conflict-free).
REQ-023 SHALL treat p_be=0 writes as accepted no-ops.
REQ-024 SHALL serialise same-word accesses from both ports, since they always share a bank; the later-granted access sees the earlier write.

Reset
REQ-025 SHALL, while arst_n=0, force a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, and rr=port a, independent of clk.
REQ-026 SHALL not reset memory contents; a read of an unwritten word returns an undefined value.
REQ-027 SHALL drop a read accepted in the cycle reset asserts: no p_rvalid after release.
REQ-028 SHALL hold p_ready low while arst_n=0.

Configuration
REQ-029 SHALL compile conflict statistics only when macro SRAM_BANKED_PERF_EN is defined.
REQ-030 SHALL, with SRAM_BANKED_PERF_EN defined, add output conflict_cnt [31:0]: counts cycles in which any valid request is stalled by REQ-018, saturates at 32'hFFFFFFFF, and resets to 0.
REQ-031 SHALL, without SRAM_BANKED_PERF_EN, omit the conflict_cnt port and counter logic; all other behaviour is identical.

Verification (DATA_W=32, N_BANKS=2, ADDR_W=8)
REQ-032 Byte-enable write: a write at addr 0x10 with data 0xAABBCCDD and be=4'hF, then a write with data 0x11223344 and be=4'b0101, then a read at 0x10 -> rvalid one cycle later with rdata 0xAA22CC44.
REQ-033 Parallel access: port a reads 0x00 (bank0) while port b reads 0x04 (bank1) in the same cycle -> both ready=1; both rvalid next cycle.
REQ-034 Conflict: port a writes 0x08 and port b reads 0x08 simultaneously after reset -> a granted, b_ready=0; b granted the next cycle and returns the new data; rr=b; conflict_cnt=1 with the macro defined.
REQ-035 Fairness: both ports hammer bank0 for 6 cycles -> grants alternate a,b,a,b,a,b; each port gets 3 grants.
REQ-036 Wrap-around: write 0x12345678 at 0x400 (word 256), then read 0x000 -> rdata 0x12345678.
REQ-037 Reset mid-read: assert arst_n=0 in the cycle a read is accepted -> rvalid stays 0 and rdata=0 after release; with the macro defined, conflict_cnt=0.
